// File: rtl/ucca_pkg.sv
// ---------------------------------------------------------------------------
// ucca_pkg
// Shared constants for the UCCA reset sequencer and violation logger.
//   ST_RUN / ST_HOLD : sequencer state encoding (RUN=0, HOLD=1)
//   STAT_OFS_FLAGS   : status window byte offset of the flags/count word
//   STAT_OFS_PC      : status window byte offset of the captured PC word
//   HOLD_W           : width of the post-violation hold counter
//   VIOL_CNT_MAX     : saturation value of the violation counter
// ---------------------------------------------------------------------------
package ucca_pkg;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [15:0] STAT_OFS_FLAGS = 16'd0;
    localparam logic [15:0] STAT_OFS_PC    = 16'd2;

    localparam int HOLD_W = 4;

    localparam logic [7:0] VIOL_CNT_MAX = 8'hFF;

    // Flags word as seen by software: count in the high byte, sticky flag in bit 0.
    function automatic logic [15:0] pack_flags(input logic [7:0] cnt, input logic seen);
        return {cnt, 7'b0, seen};
    endfunction

endpackage

// File: rtl/ucca_reset_ctrl_if.sv
// ---------------------------------------------------------------------------
// ucca_reset_ctrl_if
// Data bus slice seen by the status window.
//   data_en   : access strobe (master -> slave)
//   data_wr   : write flag, 1 = write (master -> slave)
//   data_addr : byte address (master -> slave)
//   rd_data   : read data (slave -> master)
//
// Handshake: there is no ready/backpressure. A cycle with data_en=1 is an
// accepted access; for a read (data_wr=0) that hits the window, rd_data
// carries the word in the following cycle and is 0 in every other cycle.
// ---------------------------------------------------------------------------
interface ucca_reset_ctrl_if;

    logic        data_en;
    logic        data_wr;
    logic [15:0] data_addr;
    logic [15:0] rd_data;

    modport master (
        output data_en,
        output data_wr,
        output data_addr,
        input  rd_data
    );

    modport slave (
        input  data_en,
        input  data_wr,
        input  data_addr,
        output rd_data
    );

endinterface

// File: rtl/ucca_viol_log.sv
// ---------------------------------------------------------------------------
// ucca_viol_log
// Violation statistics: saturating 8-bit violation count and the PC of the
// most recent counted violation, plus the status window read mux.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   capture     : pulse on RUN -> HOLD (a new, counted violation)
//   pc          : core program counter to capture
//   viol_seen   : sticky flag from the sequencer, merged into the flags word
//   word_sel    : 0 = flags word, 1 = PC word
//   rd_word     : selected word (combinational)
// ---------------------------------------------------------------------------
module ucca_viol_log
    import ucca_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        capture,
    input  logic [15:0] pc,
    input  logic        viol_seen,
    input  logic        word_sel,
    output logic [15:0] rd_word
);

    logic [7:0]  viol_cnt;
    logic [15:0] last_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            viol_cnt <= 8'd0;
            last_pc  <= 16'd0;
        end else if (capture) begin
            last_pc <= pc;
            if (viol_cnt != VIOL_CNT_MAX) begin
                viol_cnt <= viol_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        rd_word = pack_flags(viol_cnt, viol_seen);
        if (word_sel) begin
            rd_word = last_pc;
        end
    end

endmodule

// File: rtl/ucca_reset_ctrl.sv
// ---------------------------------------------------------------------------
// ucca_reset_ctrl
// Turns the UCCA monitor's combinational violation into a core reset of
// guaranteed minimum width and exposes a read-only status window.
// Optional feature macro: UCCA_VIOLATION_LOG_EN (adds violation count and
// last-violation PC via ucca_viol_log).
// Parameters:
//   HOLD_CYCLES : cycles core_reset stays high after viol drops (1..15)
//   STAT_ADDR   : byte base address of the status window
// Ports:
//   clk, reset  : clock, synchronous active-high power-on reset
//   viol        : violation from the hardware monitor (combinational)
//   pc          : current core program counter
//   bus         : data bus slice (slave side), see ucca_reset_ctrl_if
//   core_reset  : reset to the core (openMSP430 PUC)
//   state_dbg   : current sequencer state (ST_RUN / ST_HOLD)
// ---------------------------------------------------------------------------
module ucca_reset_ctrl
    import ucca_pkg::*;
#(
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] STAT_ADDR   = 16'h016A
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               viol,
    input  logic [15:0]        pc,
    ucca_reset_ctrl_if.slave   bus,
    output logic               core_reset,
    output logic [0:0]         state_dbg
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
            $error("ucca_reset_ctrl: HOLD_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [0:0]        state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              viol_seen_q;
    logic              enter_hold;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    assign enter_hold = (state_q == ST_RUN) && viol;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (viol) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            default: begin
                // A violation inside HOLD restarts the hold window.
                if (viol) begin
                    cnt_d = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            viol_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_hold) begin
                viol_seen_q <= 1'b1;
            end
        end
    end

    // viol is used combinationally so the violating access never completes.
    assign core_reset = reset | viol | (state_q == ST_HOLD);
    assign state_dbg  = state_q;

    // ------------------------------------------------------------------
    // Status window decode. Working on the offset from STAT_ADDR keeps the
    // decode correct even when the two words straddle an aligned 4-byte
    // boundary (as they do at the default base); ofs[1] picks the word.
    // ------------------------------------------------------------------
    logic [15:0] ofs;
    logic        win_hit;
    logic        rd_strobe;
    logic        word_sel;
    logic [15:0] rd_word;
    logic [15:0] rd_q;
    logic        unused_ofs_bit;

    assign ofs            = bus.data_addr - STAT_ADDR;
    assign win_hit        = (ofs[15:2] == 14'd0);
    assign word_sel       = (ofs[1] == STAT_OFS_PC[1]);
    assign rd_strobe      = bus.data_en && !bus.data_wr && win_hit;
    assign unused_ofs_bit = ofs[0];

`ifdef UCCA_VIOLATION_LOG_EN
    ucca_viol_log u_viol_log (
        .clk       (clk),
        .reset     (reset),
        .capture   (enter_hold),
        .pc        (pc),
        .viol_seen (viol_seen_q),
        .word_sel  (word_sel),
        .rd_word   (rd_word)
    );
`else
    logic unused_pc;
    assign unused_pc = ^pc;

    always_comb begin
        rd_word = pack_flags(8'd0, viol_seen_q);
        if (word_sel) begin
            rd_word = 16'd0;
        end
    end
`endif

    // Read data is registered from the pre-edge register values, so a read
    // coinciding with a violation returns the state before that violation.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= 16'd0;
        end else if (rd_strobe) begin
            rd_q <= rd_word;
        end else begin
            rd_q <= 16'd0;
        end
    end

    assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_ucca_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ucca_reset_ctrl
// Self-checking bench for ucca_reset_ctrl. Works with or without
// UCCA_VIOLATION_LOG_EN defined.
// ---------------------------------------------------------------------------
module tb_ucca_reset_ctrl;

    localparam int          HOLD  = 4;
    localparam logic [15:0] SBASE = 16'h016A;
`ifdef UCCA_VIOLATION_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        viol  = 1'b0;
    logic [15:0] pc    = 16'h0;
    logic        core_reset;
    logic [0:0]  state_dbg;

    ucca_reset_ctrl_if bus_if ();

    ucca_reset_ctrl #(
        .HOLD_CYCLES (HOLD),
        .STAT_ADDR   (SBASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .viol       (viol),
        .pc         (pc),
        .bus        (bus_if),
        .core_reset (core_reset),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Hold is active in a cycle iff some violation happened within the last
    // HOLD cycles and no reset came in between.
    int          cyc_n     = 0;
    int          last_viol = 0;
    bit          have_viol = 0;
    bit          m_seen    = 0;
    int          m_cnt     = 0;
    logic [15:0] m_pc      = 16'h0;
    logic [15:0] exp_q[$];

    function automatic bit m_hold();
        return have_viol && ((cyc_n - last_viol) <= HOLD);
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a);
        logic [15:0] o;
        o = a - SBASE;
        if (o[1] == 1'b0) return {(LOG ? 8'(m_cnt) : 8'h00), 7'b0, m_seen};
        return LOG ? m_pc : 16'h0;
    endfunction

    function automatic bit in_win(input logic [15:0] a);
        logic [15:0] o;
        o = a - SBASE;
        return o < 16'd4;
    endfunction

    logic        obs_cr;
    logic [15:0] obs_rd;

    // One clock cycle: drive at negedge, check core_reset/state mid-cycle,
    // check rd_data just after the edge.
    task automatic cyc(input logic r, input logic v, input logic [15:0] p,
                       input logic en, input logic wr, input logic [15:0] a);
        logic [15:0] e_rd;
        @(negedge clk);
        reset = r; viol = v; pc = p;
        bus_if.data_en = en; bus_if.data_wr = wr; bus_if.data_addr = a;
        #1;
        obs_cr = core_reset;
        chk("core_reset", {31'b0, core_reset}, {31'b0, (r | v | m_hold())});
        if (cyc_n > 0) chk("state", {31'b0, state_dbg}, {31'b0, m_hold()});
        e_rd = (!r && en && !wr && in_win(a)) ? m_read(a) : 16'h0;
        exp_q.push_back(e_rd);
        @(posedge clk);
        if (r) begin
            have_viol = 0; m_seen = 0; m_cnt = 0; m_pc = 16'h0;
        end else if (v) begin
            if (!m_hold()) begin
                m_seen = 1;
                if (m_cnt < 255) m_cnt++;
                m_pc = p;
            end
            have_viol = 1;
            last_viol = cyc_n;
        end
        cyc_n++;
        #1;
        obs_rd = bus_if.rd_data;
        chk("rd_data", {16'b0, obs_rd}, {16'b0, exp_q.pop_front()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic rd(input logic [15:0] a);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, a);
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic        r, v, en, wr;
        logic [15:0] p, a;
        logic        exp_cr;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input logic r, v, en, input logic [15:0] p, a,
                                input logic ecr, input logic [15:0] erd);
        vec_t t;
        t.r = r; t.v = v; t.en = en; t.wr = 1'b0; t.p = p; t.a = a;
        t.exp_cr = ecr; t.exp_rd = erd;
        return t;
    endfunction

    initial begin
        logic [15:0] addrs[6];
        bus_if.data_en = 1'b0; bus_if.data_wr = 1'b0; bus_if.data_addr = 16'h0;
        addrs[0] = 16'h016A; addrs[1] = 16'h016B; addrs[2] = 16'h016C;
        addrs[3] = 16'h016D; addrs[4] = 16'h0168; addrs[5] = 16'h016E;

        // Power-on then a single-cycle violation at row 4 (T), pc = 16'h4004.
        tbl[0] = mk(1, 0, 0, 16'h4000, 16'h0,    1, 16'h0000);
        tbl[1] = mk(1, 0, 0, 16'h4001, 16'h0,    1, 16'h0000);
        tbl[2] = mk(1, 0, 0, 16'h4002, 16'h0,    1, 16'h0000);
        tbl[3] = mk(0, 0, 1, 16'h4003, 16'h016A, 0, 16'h0000);
        tbl[4] = mk(0, 1, 0, 16'h4004, 16'h0,    1, 16'h0000);
        tbl[5] = mk(0, 0, 1, 16'h4005, 16'h016A, 1, LOG ? 16'h0101 : 16'h0001);
        tbl[6] = mk(0, 0, 1, 16'h4006, 16'h016C, 1, LOG ? 16'h4004 : 16'h0000);
        tbl[7] = mk(0, 0, 0, 16'h4007, 16'h0,    1, 16'h0000);
        tbl[8] = mk(0, 0, 0, 16'h4008, 16'h0,    1, 16'h0000);
        tbl[9] = mk(0, 0, 1, 16'h4009, 16'h016A, 0, LOG ? 16'h0101 : 16'h0001);

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].p, tbl[i].en, tbl[i].wr, tbl[i].a);
            chk($sformatf("tbl%0d_cr", i), {31'b0, obs_cr}, {31'b0, tbl[i].exp_cr});
            chk($sformatf("tbl%0d_rd", i), {16'b0, obs_rd}, {16'b0, tbl[i].exp_rd});
        end

        // Violation held for three cycles: one count, release at T+7.
        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0, 16'h0);
        idle(3);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("long_T+6", {31'b0, obs_cr}, 32'd1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("long_T+7", {31'b0, obs_cr}, 32'd0);
        rd(16'h016A);
        chk("long_cnt", {16'b0, obs_rd}, {16'b0, (LOG ? 16'h0201 : 16'h0001)});
        rd(16'h016C);
        chk("long_pc", {16'b0, obs_rd}, {16'b0, (LOG ? 16'h5000 : 16'h0000)});

        // Read in the same cycle as a violation returns pre-update values.
        cyc(1'b0, 1'b1, 16'h6000, 1'b1, 1'b0, 16'h016A);
        chk("same_cyc", {16'b0, obs_rd}, {16'b0, (LOG ? 16'h0201 : 16'h0001)});
        idle(6);

        // Saturation: 256 separated violations after a clean reset.
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        for (int k = 0; k < 256; k++) begin
            cyc(1'b0, 1'b1, 16'h7000 + 16'(k), 1'b0, 1'b0, 16'h0);
            idle(HOLD + 1);
        end
        rd(16'h016A);
        chk("sat_cnt", {16'b0, obs_rd}, {16'b0, (LOG ? 16'hFF01 : 16'h0001)});
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h016A);
        chk("wr_no_rd", {16'b0, obs_rd}, 32'd0);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h016C);
        rd(16'h016A);
        chk("wr_ignored", {16'b0, obs_rd}, {16'b0, (LOG ? 16'hFF01 : 16'h0001)});
        rd(16'h016C);
        chk("sat_pc", {16'b0, obs_rd}, {16'b0, (LOG ? 16'h70FF : 16'h0000)});

        // Reset during HOLD together with a violation.
        cyc(1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 16'h0);
        idle(1);
        cyc(1'b1, 1'b1, 16'h8001, 1'b0, 1'b0, 16'h0);
        chk("rst_hold_cr", {31'b0, obs_cr}, 32'd1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h016A);
        chk("rst_hold_cr_rel", {31'b0, obs_cr}, 32'd0);
        chk("rst_hold_state", {31'b0, state_dbg}, 32'd0);
        chk("rst_flags", {16'b0, obs_rd}, 32'd0);
        rd(16'h016C);
        chk("rst_pc", {16'b0, obs_rd}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic        r, v, en, wr;
            logic [15:0] a;
            r  = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : addrs[$urandom_range(0, 5)];
            cyc(r, v, 16'($urandom), en, wr, a);
        end
        idle(HOLD + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ucca_reset_ctrl.md
# ucca_reset_ctrl

Reset sequencer and violation logger placed directly downstream of the UCCA hardware monitor. It turns the monitor's combinational violation `reset` into a clean core reset of guaranteed minimum width. When logging is compiled in, it also records violation statistics that software can read after reboot through a memory-mapped status window. Its `core_reset` output drives the openMSP430 PUC input; the monitor's `reset` output connects to `viol`.

## Interface
Parameters:
- `HOLD_CYCLES`, 4: minimum cycles `core_reset` stays high after a violation ends; legal range 1..15.
- `STAT_ADDR`, 16'h016A: base byte address of the status window, directly above the UCCA metadata region.

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: power-on reset, synchronous and active-high.
- `viol` in 1: violation from the hardware monitor; combinational and may be asserted for any number of cycles.
- `pc` in 16: current core program counter.
- `data_en` in 1: data bus access strobe.
- `data_wr` in 1: data bus write flag.
- `data_addr` in 16: data bus byte address.
- `core_reset` out 1: reset to the core.
- `rd_data` out 16: status window read data; 0 when the window is not selected.

## Operation
- FSM has two states:
  - RUN: normal execution.
  - HOLD: core held in reset.
- `core_reset = reset | viol | (state == HOLD)`. The `viol` term is combinational so the violating access never completes.
- RUN → HOLD when `viol` = 1. The hold counter loads `HOLD_CYCLES-1`.
- HOLD behaviour:
  - If `viol` = 1, the counter reloads `HOLD_CYCLES-1`.
  - Otherwise the counter decrements.
  - HOLD → RUN when the counter is 0 and `viol` = 0.
- Sticky flag `viol_seen` sets on RUN → HOLD. Only `reset` clears it; violation-induced core resets do not.
- Logging (see Configuration):
  - On each RUN → HOLD transition, `pc` is captured into `last_pc`.
  - `viol_cnt` (8 bit) increments and saturates at 255.
  - Violations that extend an active HOLD are not counted.
- Status window, read-only:
  - `STAT_ADDR`+0 returns {`viol_cnt`[7:0], 7'b0, `viol_seen`}.
  - `STAT_ADDR`+2 returns `last_pc`.
  - Writes to either address are ignored. Only bit 1 of the address selects the word.

## Timing
- Reset values: state RUN, counter 0, `viol_seen` 0, `viol_cnt` 0, `last_pc` 0, `rd_data` 0. `core_reset` is 1 while `reset` = 1.
- Single-cycle violation at cycle T: `core_reset` is high for cycles T..T+`HOLD_CYCLES` and low from T+`HOLD_CYCLES`+1.
- Violation held high for cycles T..T+k: `core_reset` is low from T+k+`HOLD_CYCLES`+1.
- Read latency is 1 cycle. A read at cycle T (`data_en`=1, `data_wr`=0, address in window) presents data in cycle T+1. `rd_data` is 0 in every other cycle.
- A read and a violation in the same cycle return pre-update values.
- `reset` in any state forces RUN and clears everything on the next edge. It overrides a simultaneous `viol`: no flag set, no count.
- Counter is 4 bit; `HOLD_CYCLES` ≥ 16 is a parameter error. Flag it with an elaboration-time check.

## Configuration
- `UCCA_VIOLATION_LOG_EN` defined: `viol_cnt` and `last_pc` are implemented and readable as described.
- Macro undefined:
  - Neither register exists.
  - `STAT_ADDR`+0 reads {15'b0, `viol_seen`} and `STAT_ADDR`+2 reads 0.
  - The FSM, hold timing and `core_reset` are identical to the logging build.

## Structure
- Shared package `ucca_pkg` holds:
  - the state encoding (RUN=0, HOLD=1);
  - window offsets `STAT_OFS_FLAGS`=0 and `STAT_OFS_PC`=2;
  - `HOLD_W`=4;
  - `VIOL_CNT_MAX`=8'hFF.
- One sub-module, `ucca_viol_log`, contains the count and PC capture registers plus their read mux. It is instantiated only under `UCCA_VIOLATION_LOG_EN`. The top level contains the FSM, hold counter, flag and address decode.

## Test plan
- Power-on: `reset` high for 3 cycles, then low → `core_reset` 1 during reset then 0; read at 16'h016A → 16'h0000.
- Single-cycle `viol` at T, `HOLD_CYCLES`=4 → `core_reset` high T..T+4, low at T+5; read 16'h016A → 16'h0101; read 16'h016C → `pc` at T.
- `viol` high 3 cycles (T..T+2) → `core_reset` low at T+7; `viol_cnt` = 1, not 3.
- 256 separated violations → `viol_cnt` reads 8'hFF, no wrap; write to 16'h016A → value unchanged.
- `reset` asserted during HOLD with a simultaneous `viol` → state RUN; all status reads 0 after release.
- Macro undefined, one violation → 16'h016A reads 16'h0001, 16'h016C reads 0; `core_reset` timing identical to the logging build.
